// File: rtl/spm_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spm_loader_pkg
// Description : Shared bus encodings and loader state codes for spm_loader.
// Revision    : 1.0 - initial release
// ============================================================================
package spm_loader_pkg;

    // SPM bus direction and active-low strobe levels
    localparam logic c_READ     = 1'b1;
    localparam logic c_WRITE    = 1'b0;
    localparam logic c_ENABLE_  = 1'b0;
    localparam logic c_DISABLE_ = 1'b1;

    typedef enum logic [2:0] {
        LD_HDR   = 3'd0,
        LD_DATA  = 3'd1,
        LD_WRITE = 3'd2,
        LD_DONE  = 3'd3,
        LD_ERR   = 3'd4
    } ld_state_t;

endpackage : spm_loader_pkg
`default_nettype wire

// File: rtl/spm_loader.sv
`default_nettype none
// ============================================================================
// Module      : spm_loader
// Description : Boot-time byte-stream to SPM word writer; holds the CPU off
//               until the whole image is written.
// Revision    : 1.0 - initial release
// ============================================================================
module spm_loader
    import spm_loader_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                MAX_WORDS = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    input  logic              load_req,
    output logic [ADDR_W-1:0] mem_spm_addr,
    output logic              mem_spm_as_,
    output logic              mem_spm_rw,
    output logic [31:0]       mem_spm_wr_data,
    output logic              cpu_en,
    output logic              load_err,
    output logic [15:0]       words_loaded
);

    ld_state_t         r_state,    w_state_nxt;
    logic [31:0]       r_shift,    w_shift_nxt;
    logic [1:0]        r_byte_cnt, w_byte_cnt_nxt;
    logic [31:0]       r_n,        w_n_nxt;
    logic [15:0]       r_words,    w_words_nxt;
    logic [ADDR_W-1:0] r_addr,     w_addr_nxt;
    logic              r_as_,      w_as_nxt;
    logic              r_rw,       w_rw_nxt;
    logic [31:0]       r_wdata,    w_wdata_nxt;
    logic              r_cpu_en,   w_cpu_en_nxt;
    logic              r_err,      w_err_nxt;

    logic              w_fire;
    logic [31:0]       w_word;
    logic [ADDR_W-1:0] w_word_addr;

    assign rx_ready    = !reset && (r_state == LD_HDR || r_state == LD_DATA);
    assign w_fire      = rx_valid && rx_ready;
    // Little-endian assembly: each new byte enters at the top, so after four
    // bytes the first one sits in [7:0].
    assign w_word      = {rx_data, r_shift[31:8]};
    assign w_word_addr = BASE_ADDR + (ADDR_W'(r_words) << 2);

    always_comb begin
        w_state_nxt    = r_state;
        w_shift_nxt    = r_shift;
        w_byte_cnt_nxt = r_byte_cnt;
        w_n_nxt        = r_n;
        w_words_nxt    = r_words;
        w_addr_nxt     = r_addr;
        w_as_nxt       = c_DISABLE_;
        w_rw_nxt       = c_READ;
        w_wdata_nxt    = r_wdata;
        w_cpu_en_nxt   = r_cpu_en;
        w_err_nxt      = r_err;

        case (r_state)
            LD_HDR: begin
                if (w_fire) begin
                    w_shift_nxt    = w_word;
                    w_byte_cnt_nxt = r_byte_cnt + 2'd1;
                    if (r_byte_cnt == 2'd3) begin
                        w_n_nxt = w_word;
                        if (w_word > 32'(MAX_WORDS)) begin
                            w_state_nxt = LD_ERR;
                            w_err_nxt   = 1'b1;
                        end else if (w_word == 32'd0) begin
                            w_state_nxt  = LD_DONE;
                            w_cpu_en_nxt = 1'b1;
                        end else begin
                            w_state_nxt = LD_DATA;
                        end
                    end
                end
            end
            LD_DATA: begin
                if (w_fire) begin
                    w_shift_nxt    = w_word;
                    w_byte_cnt_nxt = r_byte_cnt + 2'd1;
                    // Strobe outputs are registered, so they are loaded here
                    // to be valid throughout the WRITE cycle.
                    if (r_byte_cnt == 2'd3) begin
                        w_state_nxt = LD_WRITE;
                        w_as_nxt    = c_ENABLE_;
                        w_rw_nxt    = c_WRITE;
                        w_addr_nxt  = w_word_addr;
                        w_wdata_nxt = w_word;
                    end
                end
            end
            LD_WRITE: begin
                w_words_nxt = r_words + 16'd1;
                if (32'(r_words) + 32'd1 == r_n) begin
                    w_state_nxt  = LD_DONE;
                    w_cpu_en_nxt = 1'b1;
                end else begin
                    w_state_nxt = LD_DATA;
                end
            end
            LD_DONE, LD_ERR: begin
                if (load_req) begin
                    w_state_nxt    = LD_HDR;
                    w_cpu_en_nxt   = 1'b0;
                    w_err_nxt      = 1'b0;
                    w_words_nxt    = 16'd0;
                    w_byte_cnt_nxt = 2'd0;
                end
            end
            default: begin
                w_state_nxt = LD_HDR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= LD_HDR;
            r_shift    <= 32'd0;
            r_byte_cnt <= 2'd0;
            r_n        <= 32'd0;
            r_words    <= 16'd0;
            r_addr     <= BASE_ADDR;
            r_as_      <= c_DISABLE_;
            r_rw       <= c_READ;
            r_wdata    <= 32'd0;
            r_cpu_en   <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_byte_cnt <= w_byte_cnt_nxt;
            r_n        <= w_n_nxt;
            r_words    <= w_words_nxt;
            r_addr     <= w_addr_nxt;
            r_as_      <= w_as_nxt;
            r_rw       <= w_rw_nxt;
            r_wdata    <= w_wdata_nxt;
            r_cpu_en   <= w_cpu_en_nxt;
            r_err      <= w_err_nxt;
        end
    end

    assign mem_spm_addr    = r_addr;
    assign mem_spm_as_     = r_as_;
    assign mem_spm_rw      = r_rw;
    assign mem_spm_wr_data = r_wdata;
    assign cpu_en          = r_cpu_en;
    assign load_err        = r_err;
    assign words_loaded    = r_words;

endmodule : spm_loader
`default_nettype wire

// File: doc/spm_loader.md
Name: spm_loader

Overview:
- Boot-time writer for the SPM. It receives a byte stream (program image) over a valid/ready interface and assembles little-endian 32-bit words.
- It writes those words into the SPM through the mem_spm_* port and then asserts cpu_en, so the fetch stage reads the freshly loaded instructions.
- It holds the CPU disabled during loading.

Parameters:
- BASE_ADDR, 0, SPM byte address of the first loaded word.
- MAX_WORDS, 1024, largest accepted word count; the header is rejected above this.
- ADDR_W, 32, width of mem_spm_addr; must match the SPM port width.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- rx_valid  in  1  a byte is offered on rx_data.
- rx_data  in  8  stream byte.
- rx_ready  out  1  loader accepts a byte this cycle; the transfer happens when rx_valid && rx_ready.
- load_req  in  1  one-cycle pulse; restarts loading from DONE or ERR.
- mem_spm_addr  out  ADDR_W  SPM byte address.
- mem_spm_as_  out  1  address strobe, active-low.
- mem_spm_rw  out  1  `READ/`WRITE (from define.v).
- mem_spm_wr_data  out  32  assembled word.
- cpu_en  out  1  high once the image is completely written.
- load_err  out  1  header word count was greater than MAX_WORDS.
- words_loaded  out  16  count of words written in the current load.

Behaviour:
- Reset is synchronous and active-high. One clock domain (clk).
- Reset values, all registered: state=HDR, mem_spm_as_=1, mem_spm_rw=`READ, mem_spm_addr=BASE_ADDR, mem_spm_wr_data=0, cpu_en=0, load_err=0, words_loaded=0, byte_cnt=0. rx_ready is forced 0 while reset=1.
- rx_ready=1 in HDR and DATA; 0 in WRITE, DONE and ERR.
- Stream format: 4 header bytes give word count N, LSB first. Then N words follow, 4 bytes each, LSB first. Byte k of a word lands in bits [8k+7:8k].
- HDR:
  - Shift accepted bytes into N.
  - On the 4th byte: if N > MAX_WORDS, go to ERR. If N == 0, go to DONE. Otherwise go to DATA.
- DATA:
  - Shift bytes into wr_data.
  - On the 4th accepted byte, go to WRITE on the next edge. The word is presented in the WRITE cycle.
- WRITE (exactly 1 cycle):
  - mem_spm_as_=0, mem_spm_rw=`WRITE, mem_spm_addr = BASE_ADDR + 4*words_loaded, mem_spm_wr_data = assembled word.
  - At the end of the cycle, words_loaded increments.
  - Then go to DONE if words_loaded+1 == N, else back to DATA.
  - Outside WRITE: mem_spm_as_=1 and mem_spm_rw=`READ.
- Latency: the write strobe occurs 1 cycle after the 4th byte handshake. Minimum is 5 cycles per word at full rx_valid rate.
- DONE:
  - cpu_en=1 starting in the first DONE cycle and held.
  - Bytes arriving here are not accepted (rx_ready=0).
- ERR: load_err=1 and cpu_en=0, held.
- load_req:
  - In DONE or ERR: clears cpu_en, load_err, words_loaded and byte_cnt, then goes to HDR.
  - In HDR, DATA or WRITE: ignored.
- rx_valid may drop mid-word; partially assembled bytes are retained and byte_cnt is not reset.
- Reset mid-load: returns to HDR with all counters cleared. No SPM write is issued in the reset cycle, and a partial word is discarded.
- Address never wraps, because N ≤ MAX_WORDS. The address computation is done in ADDR_W bits.

Decomposition:
- define.v (shared): `READ, `WRITE, `ENABLE_/`DISABLE_ for the active-low strobe, and the loader state encodings (LD_HDR, LD_DATA, LD_WRITE, LD_DONE, LD_ERR, 3 bits).
- No sub-module. Byte assembly is a 32-bit shift register plus a 2-bit byte_cnt, shared by HDR and DATA. A separate module would be a thin wrapper.

Test Plan:
- Single word: stream 01 00 00 00, 93 80 16 F0 → one strobe with addr=0, data=0xF0168093, rw=`WRITE; then cpu_en=1, words_loaded=1.
- Three-word image:
  - Header N=3, then 0xF0168093, 0x00F6A093, 0x40F6D093 at full rate.
  - Required: writes to addresses 0, 4, 8 in order, each exactly 1 cycle with as_ low.
  - The fetch stage then reads the same words from if_pc 0, 4, 8.
- Backpressure and gaps: rx_valid toggled 1-0-1 mid-word, plus bytes offered during WRITE → no byte lost or duplicated, and the same data is written as in the gap-free case.
- Zero and oversized header:
  - N=0 → DONE, cpu_en=1, no strobe.
  - N=MAX_WORDS+1 (0x401) → load_err=1, cpu_en=0, no strobe.
  - load_req then restarts in HDR.
- Reset mid-load: assert reset after 2 of 4 bytes of word 2 → no strobe, outputs return to reset values. A fresh N=1 load then writes to BASE_ADDR.
- Reload: after DONE, pulse load_req and send N=1, 0xDEADBEEF → cpu_en drops to 0 the next cycle, the write goes to addr 0, then cpu_en=1 again.
